// File: rtl/fft_out_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 16-point FFT output stream.
// FFT_REORDER_PINGPONG_EN selects two ping-pong banks; undefined gives one bank that fills, then drains.
module fft_out_reorder #(
    parameter int DW     = 16,
    parameter int N_LOG2 = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_push,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          in_stall,
    output logic          out_push_F,
    output logic [DW-1:0] out_real_F,
    output logic [DW-1:0] out_imag_F,
    output logic          out_last_F,
    input  logic          out_stall
);
    localparam int NPTS = 1 << N_LOG2;

    if (N_LOG2 != 4) begin : g_bad_size
        $error("fft_out_reorder supports only N_LOG2 == 4");
    end

`ifdef FFT_REORDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int AW = $clog2(NB * NPTS);

    typedef logic [2*DW-1:0] bin_t;

    bin_t          mem [NB*NPTS];
    logic [3:0]    wcnt;
    logic [3:0]    rcnt;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          wfull;
    logic          rfull;
    logic          accept;
    logic          issue;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    assign in_stall = wfull;
    assign accept   = in_push && !wfull;
    assign issue    = rfull && !out_stall;

`ifdef FFT_REORDER_PINGPONG_EN
    logic [1:0] full;
    logic       wbank;
    logic       rbank;

    assign wfull = full[wbank];
    assign rfull = full[rbank];
    assign waddr = {wbank, bitrev4(wcnt)};
    assign raddr = {rbank, rcnt};

    // Fill and drain always target different banks, so both updates may land on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else begin
            if (accept && wcnt == 4'd15) begin
                full[wbank] <= 1'b1;
                wbank       <= ~wbank;
            end
            if (issue && rcnt == 4'd15) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
        end
    end
`else
    logic full;

    assign wfull = full;
    assign rfull = full;
    assign waddr = bitrev4(wcnt);
    assign raddr = rcnt;

    // Writes need !full and reads need full, so set and clear are mutually exclusive.
    always_ff @(posedge clk) begin
        if (reset)
            full <= 1'b0;
        else if (accept && wcnt == 4'd15)
            full <= 1'b1;
        else if (issue && rcnt == 4'd15)
            full <= 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (accept && !reset)
            mem[waddr] <= {in_real, in_imag};
    end

    always_ff @(posedge clk) begin
        if (reset)
            wcnt <= 4'd0;
        else if (accept)
            wcnt <= wcnt + 4'd1;
    end

    // Data outputs hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt       <= 4'd0;
            out_push_F <= 1'b0;
            out_last_F <= 1'b0;
            out_real_F <= '0;
            out_imag_F <= '0;
        end else begin
            out_push_F <= issue;
            out_last_F <= issue && rcnt == 4'd15;
            if (issue) begin
                {out_real_F, out_imag_F} <= mem[raddr];
                rcnt                     <= rcnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: frame-queue reference model plus per-scenario checks.
module tb_fft_out_reorder;
    localparam int DW = 16;
`ifdef FFT_REORDER_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_push = 1'b0;
    logic [DW-1:0] in_real = '0;
    logic [DW-1:0] in_imag = '0;
    logic          in_stall;
    logic          out_push_F;
    logic [DW-1:0] out_real_F;
    logic [DW-1:0] out_imag_F;
    logic          out_last_F;
    logic          out_stall = 1'b0;

    fft_out_reorder #(.DW(DW), .N_LOG2(4)) dut (
        .clk(clk), .reset(reset),
        .in_push(in_push), .in_real(in_real), .in_imag(in_imag), .in_stall(in_stall),
        .out_push_F(out_push_F), .out_real_F(out_real_F), .out_imag_F(out_imag_F),
        .out_last_F(out_last_F), .out_stall(out_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_out = 0;

    // Reference model: complete frames are kept in arrival order and read out as frame[bitrev(i)].
    typedef logic [2*DW-1:0] frame_t [16];
    frame_t        fq[$];
    frame_t        part;
    int            pcnt = 0;
    int            ridx = 0;
    logic          m_push = 1'b0;
    logic          m_last = 1'b0;
    logic [DW-1:0] m_real = '0;
    logic [DW-1:0] m_imag = '0;

    logic          g_push, g_last, g_stall, g_acc;
    logic [DW-1:0] g_real;

    function automatic int bitrev4(int v);
        return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
    endfunction

    task automatic cycle(input logic rst, input logic push, input logic [DW-1:0] re,
                         input logic [DW-1:0] im, input logic ost);
        logic stall_e, issue, acc;
        reset = rst; in_push = push; in_real = re; in_imag = im; out_stall = ost;
        #1;
        stall_e = (fq.size() >= CAP);
        checks++;
        if (in_stall !== stall_e) begin
            failures++;
            $display("FAIL in_stall cyc=%0d got=%b exp=%b", cyc, in_stall, stall_e);
        end
        g_stall = in_stall;
        issue = !rst && fq.size() > 0 && !ost;
        acc = !rst && push && !stall_e;
        g_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            fq.delete(); pcnt = 0; ridx = 0;
            m_push = 0; m_last = 0; m_real = '0; m_imag = '0;
        end else begin
            m_push = issue;
            m_last = 1'b0;
            if (issue) begin
                {m_real, m_imag} = fq[0][bitrev4(ridx)];
                m_last = (ridx == 15);
                ridx++;
                if (ridx == 16) begin
                    ridx = 0;
                    void'(fq.pop_front());
                end
            end
            if (acc) begin
                part[pcnt] = {re, im};
                pcnt++;
                if (pcnt == 16) begin
                    fq.push_back(part);
                    pcnt = 0;
                end
            end
        end
        checks++;
        if ({out_push_F, out_last_F, out_real_F, out_imag_F} !== {m_push, m_last, m_real, m_imag}) begin
            failures++;
            $display("FAIL outputs cyc=%0d got push=%b last=%b re=%h im=%h exp push=%b last=%b re=%h im=%h",
                     cyc, out_push_F, out_last_F, out_real_F, out_imag_F, m_push, m_last, m_real, m_imag);
        end
        g_push = out_push_F; g_last = out_last_F; g_real = out_real_F;
        if (out_push_F === 1'b1) n_out++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((fq.size() > 0 || ridx != 0) && n < 200) begin
            cycle(0, 0, '0, '0, 0);
            n++;
        end
        checks++;
        if (fq.size() != 0) begin
            failures++;
            $display("FAIL %s drain timeout got=%0d frames left exp=0", name, fq.size());
        end
        cycle(0, 0, '0, '0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_push_F, out_last_F, out_real_F, out_imag_F} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got push=%b last=%b re=%h im=%h exp all 0",
                     out_push_F, out_last_F, out_real_F, out_imag_F);
        end
        cycle(0, 0, '0, '0, 0);
        checks++;
        if (g_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_stall got=%b exp=0", g_stall);
        end
    endtask

    task automatic test_single_frame();
        int exp_r[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        int first = -1, lastacc = -1, idx = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 16) cycle(0, 1, DW'(c), DW'(-c), 0);
            else        cycle(0, 0, '0, '0, 0);
            if (g_acc) lastacc = cyc;
            if (g_push) begin
                if (first < 0) first = cyc;
                if (idx < 16) begin
                    checks++;
                    if (g_real !== DW'(exp_r[idx]) || g_last !== (idx == 15)) begin
                        failures++;
                        $display("FAIL single_order idx=%0d got re=%0d last=%b exp re=%0d last=%b",
                                 idx, g_real, g_last, exp_r[idx], idx == 15);
                    end
                end
                idx++;
            end
        end
        checks++;
        if (idx != 16) begin
            failures++;
            $display("FAIL single_count got=%0d exp=16", idx);
        end
        checks++;
        if (first != lastacc + 1) begin
            failures++;
            $display("FAIL single_latency got first=%0d exp=%0d", first, lastacc + 1);
        end
    endtask

    task automatic test_back_to_back();
        int stalls = 0, gaps = 0, started = 0, t0 = -1, t1 = -1, base = n_out;
        bit ok;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 16; p++) begin
                ok = 0;
                for (int a = 0; a < 64 && !ok; a++) begin
                    cycle(0, 1, DW'(16 * f + p), DW'($urandom), 0);
                    if (g_stall) stalls++;
                    if (g_push) started = 1;
                    else if (started && n_out - base < 48) gaps++;
                    if (g_acc) begin
                        ok = 1;
                        if (p == 0 && f == 0) t0 = cyc;
                        if (p == 0 && f == 1) t1 = cyc;
                    end
                end
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL b2b_accept_timeout frame=%0d bin=%0d got=stalled exp=accepted", f, p);
                end
            end
        end
        for (int c = 0; c < 200 && (fq.size() > 0 || ridx != 0); c++) begin
            cycle(0, 0, '0, '0, 0);
            if (!g_push && n_out - base < 48) gaps++;
        end
        checks++;
        if (n_out - base != 48) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=48", n_out - base);
        end
`ifdef FFT_REORDER_PINGPONG_EN
        checks++;
        if (stalls != 0 || gaps != 0) begin
            failures++;
            $display("FAIL b2b_stream got stalls=%0d gaps=%0d exp stalls=0 gaps=0", stalls, gaps);
        end
`else
        checks++;
        if (stalls != 32) begin
            failures++;
            $display("FAIL single_bank_stall got=%0d exp=32", stalls);
        end
        checks++;
        if (t1 - t0 != 32) begin
            failures++;
            $display("FAIL single_bank_period got=%0d exp=32", t1 - t0);
        end
`endif
        cycle(0, 0, '0, '0, 0);
    endtask

    task automatic test_backpressure();
        int acc = 0, first_stall = -1, base;
        for (int a = 0; a < 48; a++) begin
            cycle(0, 1, DW'($urandom), DW'($urandom), 1);
            if (g_stall && first_stall < 0) first_stall = a;
            if (g_acc) acc++;
        end
        checks++;
        if (acc != 16 * CAP || first_stall != 16 * CAP) begin
            failures++;
            $display("FAIL bp_fill got acc=%0d first_stall=%0d exp acc=%0d first_stall=%0d",
                     acc, first_stall, 16 * CAP, 16 * CAP);
        end
        base = n_out;
        drain("bp");
        checks++;
        if (n_out - base != 16 * CAP) begin
            failures++;
            $display("FAIL bp_drain_count got=%0d exp=%0d", n_out - base, 16 * CAP);
        end
    endtask

    task automatic test_toggle_stall();
        int k = 0, pushed = 0, base = n_out;
        logic ost;
        while ((pushed < 32 || fq.size() > 0 || ridx != 0) && k < 400) begin
            ost = (k % 3 == 0);
            if (pushed < 32) cycle(0, 1, DW'($urandom), DW'($urandom), ost);
            else             cycle(0, 0, '0, '0, ost);
            if (g_acc) pushed++;
            checks++;
            if (g_push && ost) begin
                failures++;
                $display("FAIL toggle_push_after_stall cyc=%0d got push=1 exp=0", cyc);
            end
            k++;
        end
        checks++;
        if (n_out - base != 32) begin
            failures++;
            $display("FAIL toggle_count got=%0d exp=32", n_out - base);
        end
        cycle(0, 0, '0, '0, 0);
    endtask

    task automatic test_reset_mid();
        int base, p = 0;
        for (int c = 0; c < 16; c++) cycle(0, 1, DW'($urandom), DW'($urandom), 0);
        for (int c = 0; c < 7; c++)  cycle(0, 1, DW'($urandom), DW'($urandom), 0);
        cycle(1, 0, '0, '0, 0);
        checks++;
        if (g_push !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_push got=%b exp=0", g_push);
        end
        base = n_out;
        for (int a = 0; a < 64 && p < 16; a++) begin
            cycle(0, 1, DW'($urandom), DW'($urandom), 0);
            if (a == 0) begin
                checks++;
                if (g_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_reset_in_stall got=%b exp=0", g_stall);
                end
            end
            if (g_acc) p++;
        end
        drain("mid_reset");
        checks++;
        if (n_out - base != 16) begin
            failures++;
            $display("FAIL mid_reset_fresh_count got=%0d exp=16", n_out - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_toggle_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
